// File: rtl/nios2_debug_pkg.sv
// Shared IR channel codes and the default-geometry command entry for the Nios II debug slave.
package nios2_debug_pkg;
   localparam int DBG_IR_WIDTH = 2;
   localparam int DBG_SR_WIDTH = 38;
   localparam int DBG_ACT_BIT  = 34;

   localparam logic [DBG_IR_WIDTH-1:0] DBG_IR_OCIMEM    = 2'd0;
   localparam logic [DBG_IR_WIDTH-1:0] DBG_IR_TRACEMEM  = 2'd1;
   localparam logic [DBG_IR_WIDTH-1:0] DBG_IR_BREAK     = 2'd2;
   localparam logic [DBG_IR_WIDTH-1:0] DBG_IR_TRACECTRL = 2'd3;

   typedef struct packed {
      logic [DBG_IR_WIDTH-1:0] ir;
      logic [DBG_SR_WIDTH-1:0] data;
   } dbg_cmd_t;
endpackage

// File: rtl/nios2_debug_sync_edge.sv
// Async level synchroniser with arm gate and rising-edge pulse; event visible STAGES edges after input rises.
// The chain only arms after a settled low, so a level already high at reset release never fires.
module nios2_debug_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic async_in,
   output logic evt
);
   logic [STAGES-1:0] chain;
   logic [STAGES-1:0] fill;
   logic              prev;
   logic              armed;
   logic              synced;

   assign synced = chain[STAGES-1];

   // fill marks when the chain holds real samples rather than reset zeros
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         chain <= '0;
         fill  <= '0;
         prev  <= 1'b0;
         armed <= 1'b0;
      end else begin
         chain <= {chain[STAGES-2:0], async_in};
         fill  <= {fill[STAGES-2:0], 1'b1};
         prev  <= synced;
         if (fill[STAGES-1] && !synced)
            armed <= 1'b1;
      end
   end

   assign evt = armed & synced & ~prev;
endmodule

// File: rtl/nios2_debug_slave_cmd_queue.sv
// Sysclk-side debug command receiver: syncs update strobes, queues {ir, sr}, issues under valid/ready.
// cmd_valid rises SYNC_STAGES+1 edges after vs_udr is sampled high; full queue drops and counts.
module nios2_debug_slave_cmd_queue
   import nios2_debug_pkg::*;
#(
   parameter int IR_WIDTH    = DBG_IR_WIDTH,
   parameter int SR_WIDTH    = DBG_SR_WIDTH,
   parameter int SYNC_STAGES = 2,
   parameter int DEPTH       = 4,
   parameter int ACT_BIT     = DBG_ACT_BIT,
   parameter int OVF_WIDTH   = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       vs_udr,
   input  logic                       vs_uir,
   input  logic [IR_WIDTH-1:0]        ir_in,
   input  logic [SR_WIDTH-1:0]        sr,
   input  logic                       cmd_ready,
   input  logic                       ovf_clear,
   output logic                       cmd_valid,
   output logic [IR_WIDTH-1:0]        cmd_ir,
   output logic [SR_WIDTH-1:0]        jdo,
   output logic [(2**IR_WIDTH)-1:0]   take_action,
   output logic [(2**IR_WIDTH)-1:0]   take_no_action,
   output logic                       ir_update,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic [OVF_WIDTH-1:0]       ovf_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef struct packed {
      logic [IR_WIDTH-1:0] ir;
      logic [SR_WIDTH-1:0] data;
   } cmd_entry_t;

   cmd_entry_t        mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [LW-1:0]     level;
   logic              udr_evt;
   logic              uir_evt;
   logic              full;
   logic              issue;
   logic              push;
   logic              drop;
   cmd_entry_t        head;

   nios2_debug_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_udr (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_in (vs_udr),
      .evt      (udr_evt)
   );

   nios2_debug_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_uir (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_in (vs_uir),
      .evt      (uir_evt)
   );

   assign cmd_valid = (level != '0);
   assign full      = (level == LW'(DEPTH));
   assign issue     = cmd_valid & cmd_ready;
   // a pop in the same cycle frees the slot, so a full queue still accepts
   assign push      = udr_evt & (~full | issue);
   assign drop      = udr_evt & full & ~issue;

   assign head      = mem[rd_ptr];
   assign cmd_ir    = cmd_valid ? head.ir   : '0;
   assign jdo       = cmd_valid ? head.data : '0;
   assign ir_update = uir_evt;
   assign fifo_level = level;

   always_comb begin
      take_action    = '0;
      take_no_action = '0;
      if (issue) begin
         take_action[cmd_ir]    = jdo[ACT_BIT];
         take_no_action[cmd_ir] = ~jdo[ACT_BIT];
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= '{ir: ir_in, data: sr};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (issue)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, issue})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf_count <= '0;
      end else if (ovf_clear) begin
         ovf_count <= drop ? OVF_WIDTH'(1) : '0;
      end else if (drop && (ovf_count != '1)) begin
         ovf_count <= ovf_count + OVF_WIDTH'(1);
      end
   end
endmodule

// File: tb/tb_nios2_debug_slave_cmd_queue.sv
// Directed bench for the debug command queue: latency, overrun, coincident push/pop, saturation, reset.
module tb_nios2_debug_slave_cmd_queue;
   import nios2_debug_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        vs_udr, vs_uir;
   logic [1:0]  ir_in;
   logic [37:0] sr;
   logic        cmd_ready, ovf_clear;
   logic        cmd_valid;
   logic [1:0]  cmd_ir;
   logic [37:0] jdo;
   logic [3:0]  take_action, take_no_action;
   logic        ir_update;
   logic [2:0]  fifo_level;
   logic [7:0]  ovf_count;

   int checks = 0;
   int failures = 0;
   dbg_cmd_t exp_q[$];

   always #5 clk = ~clk;

   nios2_debug_slave_cmd_queue dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .vs_udr         (vs_udr),
      .vs_uir         (vs_uir),
      .ir_in          (ir_in),
      .sr             (sr),
      .cmd_ready      (cmd_ready),
      .ovf_clear      (ovf_clear),
      .cmd_valid      (cmd_valid),
      .cmd_ir         (cmd_ir),
      .jdo            (jdo),
      .take_action    (take_action),
      .take_no_action (take_no_action),
      .ir_update      (ir_update),
      .fifo_level     (fifo_level),
      .ovf_count      (ovf_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // called at a negedge; leaves inputs settled at a negedge
   task automatic udr_pulse(input logic [1:0] ir, input logic [37:0] d);
      ir_in  = ir;
      sr     = d;
      vs_udr = 1'b1;
      repeat (3) @(negedge clk);
      vs_udr = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic drain(input int n);
      int got;
      dbg_cmd_t e;
      logic [3:0] ea, en;
      got = 0;
      cmd_ready = 1'b1;
      for (int c = 0; c < 40 && got < n; c++) begin
         #1;
         if (cmd_valid) begin
            e  = exp_q.pop_front();
            ea = e.data[34] ? (4'b0001 << e.ir) : 4'b0000;
            en = e.data[34] ? 4'b0000 : (4'b0001 << e.ir);
            check("drain_jdo", 64'(jdo), 64'(e.data));
            check("drain_ir", 64'(cmd_ir), 64'(e.ir));
            check("drain_act", 64'(take_action), 64'(ea));
            check("drain_nact", 64'(take_no_action), 64'(en));
            got++;
         end
         @(negedge clk);
      end
      cmd_ready = 1'b0;
      check("drain_count", 64'(got), 64'(n));
      check("drain_level", 64'(fifo_level), 64'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; vs_udr = 1'b1; vs_uir = 1'b0; ir_in = '0; sr = '0;
      cmd_ready = 1'b0; ovf_clear = 1'b0;

      // 1: reset state, strobe held high across release
      #23;
      check("rst_valid", 64'(cmd_valid), 64'd0);
      check("rst_jdo", 64'(jdo), 64'd0);
      check("rst_level", 64'(fifo_level), 64'd0);
      check("rst_ovf", 64'(ovf_count), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("held_udr_valid", 64'(cmd_valid), 64'd0);
      end
      check("held_udr_level", 64'(fifo_level), 64'd0);
      vs_udr = 1'b0;
      repeat (6) @(negedge clk);

      // 2: single command, latency and action decode
      cmd_ready = 1'b1;
      ir_in = DBG_IR_BREAK; sr = 38'h4_0000_0ABC;
      vs_udr = 1'b1;
      @(negedge clk);
      check("lat_e1_valid", 64'(cmd_valid), 64'd0);
      @(negedge clk);
      check("lat_e2_valid", 64'(cmd_valid), 64'd0);
      @(negedge clk);
      check("lat_e3_valid", 64'(cmd_valid), 64'd1);
      check("lat_act", 64'(take_action), 64'h4);
      check("lat_nact", 64'(take_no_action), 64'h0);
      check("lat_jdo", 64'(jdo), 64'h4_0000_0ABC);
      vs_udr = 1'b0;
      @(negedge clk);
      check("lat_e4_valid", 64'(cmd_valid), 64'd0);
      check("lat_e4_act", 64'(take_action), 64'h0);
      cmd_ready = 1'b0;
      repeat (3) @(negedge clk);

      // ir_update pulse, no queue effect
      vs_uir = 1'b1;
      @(negedge clk);
      check("uir_e1", 64'(ir_update), 64'd0);
      @(negedge clk);
      check("uir_e2", 64'(ir_update), 64'd1);
      @(negedge clk);
      check("uir_e3", 64'(ir_update), 64'd0);
      check("uir_level", 64'(fifo_level), 64'd0);
      vs_uir = 1'b0;
      repeat (3) @(negedge clk);

      // 3: overrun with six commands into a four-entry queue
      for (int i = 0; i < 6; i++) begin
         udr_pulse(DBG_IR_TRACEMEM, 38'h10 + 38'(i));
         if (i < 4) exp_q.push_back('{ir: DBG_IR_TRACEMEM, data: 38'h10 + 38'(i)});
      end
      check("ovr_level", 64'(fifo_level), 64'd4);
      check("ovr_count", 64'(ovf_count), 64'd2);
      drain(4);

      // 4: full queue, push coincident with issue
      for (int i = 0; i < 4; i++)
         udr_pulse(DBG_IR_TRACECTRL, 38'h4_0000_00A0 + 38'(i));
      ir_in = DBG_IR_OCIMEM; sr = 38'h0_0000_00B5;
      vs_udr = 1'b1;
      @(negedge clk);
      @(negedge clk);
      cmd_ready = 1'b1;
      #1;
      check("coin_act", 64'(take_action), 64'h8);
      check("coin_jdo", 64'(jdo), 64'h4_0000_00A0);
      @(negedge clk);
      cmd_ready = 1'b0;
      check("coin_level", 64'(fifo_level), 64'd4);
      check("coin_ovf", 64'(ovf_count), 64'd2);
      vs_udr = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 1; i < 4; i++)
         exp_q.push_back('{ir: DBG_IR_TRACECTRL, data: 38'h4_0000_00A0 + 38'(i)});
      exp_q.push_back('{ir: DBG_IR_OCIMEM, data: 38'h0_0000_00B5});
      drain(4);

      // 5: saturation and clear interactions
      for (int i = 0; i < 4; i++) begin
         udr_pulse(DBG_IR_BREAK, 38'h20 + 38'(i));
         exp_q.push_back('{ir: DBG_IR_BREAK, data: 38'h20 + 38'(i)});
      end
      for (int i = 0; i < 253; i++)
         udr_pulse(DBG_IR_BREAK, 38'h3F);
      check("sat_reach", 64'(ovf_count), 64'd255);
      udr_pulse(DBG_IR_BREAK, 38'h3F);
      check("sat_hold", 64'(ovf_count), 64'd255);
      vs_udr = 1'b1;
      @(negedge clk);
      @(negedge clk);
      ovf_clear = 1'b1;
      @(negedge clk);
      ovf_clear = 1'b0;
      check("clr_with_drop", 64'(ovf_count), 64'd1);
      vs_udr = 1'b0;
      repeat (3) @(negedge clk);
      ovf_clear = 1'b1;
      @(negedge clk);
      ovf_clear = 1'b0;
      check("clr_alone", 64'(ovf_count), 64'd0);
      check("sat_level", 64'(fifo_level), 64'd4);
      drain(4);

      // 6: reset mid-stream
      for (int i = 0; i < 3; i++)
         udr_pulse(DBG_IR_OCIMEM, 38'h4_0000_0030 + 38'(i));
      check("pre_rst_level", 64'(fifo_level), 64'd3);
      ovf_clear = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(cmd_valid), 64'd0);
      check("mid_rst_jdo", 64'(jdo), 64'd0);
      check("mid_rst_ir", 64'(cmd_ir), 64'd0);
      check("mid_rst_level", 64'(fifo_level), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      check("post_rst_level", 64'(fifo_level), 64'd0);
      check("post_rst_valid", 64'(cmd_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
